// File: rtl/ysyx_22041412_mem_arbiter_pkg.sv
// ysyx_22041412_mem_arbiter_pkg: shared state encoding, defaults and response word select for the memory arbiter
package ysyx_22041412_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_LSU  = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_t;

    localparam int IF_WAIT_MAX_DEF = 4;
    localparam int WAIT_W          = 4;

    // Picks the 32-bit instruction out of the 64-bit cache line slot.
    function automatic logic [31:0] word_sel(input logic [63:0] data, input logic hi);
        return hi ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22041412_arb_prio.sv
// ysyx_22041412_arb_prio: grant decision for IF/LSU with an IF anti-starvation wait counter
// Ports: clk, rst (sync, active high); idle = arbiter can grant this cycle;
//        if_active = an IF transaction currently owns the port; if_valid/lsu_valid = requests;
//        grant_if/grant_lsu = combinational one-hot grant, only while idle.
module ysyx_22041412_arb_prio
    import ysyx_22041412_mem_arbiter_pkg::*;
#(
    parameter int IF_WAIT_MAX = IF_WAIT_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic if_active,
    input  logic if_valid,
    input  logic lsu_valid,
    output logic grant_if,
    output logic grant_lsu
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(IF_WAIT_MAX);

    logic [WAIT_W-1:0] wait_cnt;
    logic              force_if;

    assign force_if  = if_valid && (wait_cnt == WAIT_MAX);
    assign grant_lsu = idle && lsu_valid && !force_if;
    assign grant_if  = idle && if_valid && !grant_lsu;

    // Only time spent waiting behind someone else counts; IF's own transaction does not.
    always_ff @(posedge clk) begin
        if (rst || !if_valid || grant_if)
            wait_cnt <= '0;
        else if (!if_active && wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + 1'b1;
    end

endmodule

// File: rtl/ysyx_22041412_mem_arbiter.sv
// ysyx_22041412_mem_arbiter: shares one cache port between IF reads and LSU loads/stores
// Ports: clk, rst (sync, active high);
//        IF : if_valid_i/if_addr_i request, if_ready_o pulse with 32-bit if_rdata_o, flush_i drops an in-flight fetch;
//        LSU: lsu_valid_i/lsu_we_i/lsu_addr_i/lsu_wdata_i/lsu_wstrb_i request, lsu_ready_o pulse with 64-bit lsu_rdata_o;
//        mem: mem_valid_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_wstrb_o held until mem_ready_i, data on mem_rdata_i.
module ysyx_22041412_mem_arbiter
    import ysyx_22041412_mem_arbiter_pkg::*;
#(
    parameter int IF_WAIT_MAX = IF_WAIT_MAX_DEF,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic [31:0]       if_rdata_o,
    input  logic              flush_i,
    input  logic              lsu_valid_i,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [63:0]       lsu_wdata_i,
    input  logic [7:0]        lsu_wstrb_i,
    output logic              lsu_ready_o,
    output logic [63:0]       lsu_rdata_o,
    output logic              mem_valid_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    output logic [7:0]        mem_wstrb_o,
    input  logic              mem_ready_i,
    input  logic [63:0]       mem_rdata_i
);

    arb_state_t state;
    logic       owner_if;
    logic       wsel;
    logic       drop;
    logic       grant_if;
    logic       grant_lsu;
    logic       if_addr_unused;

    // Fetch addresses are word aligned; the low bits carry no information.
    assign if_addr_unused = ^if_addr_i[1:0];

    ysyx_22041412_arb_prio #(
        .IF_WAIT_MAX(IF_WAIT_MAX)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .idle     (state == ARB_IDLE),
        .if_active(owner_if && state != ARB_IDLE),
        .if_valid (if_valid_i),
        .lsu_valid(lsu_valid_i),
        .grant_if (grant_if),
        .grant_lsu(grant_lsu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            owner_if    <= 1'b0;
            wsel        <= 1'b0;
            drop        <= 1'b0;
            if_ready_o  <= 1'b0;
            if_rdata_o  <= '0;
            lsu_ready_o <= 1'b0;
            lsu_rdata_o <= '0;
            mem_valid_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else begin
            if_ready_o  <= 1'b0;
            lsu_ready_o <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_lsu) begin
                        state       <= ARB_LSU;
                        owner_if    <= 1'b0;
                        mem_valid_o <= 1'b1;
                        mem_we_o    <= lsu_we_i;
                        mem_addr_o  <= lsu_addr_i;
                        mem_wdata_o <= lsu_wdata_i;
                        mem_wstrb_o <= lsu_wstrb_i;
                    end else if (grant_if) begin
                        state       <= ARB_IF;
                        owner_if    <= 1'b1;
                        wsel        <= if_addr_i[2];
                        mem_valid_o <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= {if_addr_i[ADDR_W-1:3], 3'b000};
                        mem_wdata_o <= '0;
                        mem_wstrb_o <= '0;
                    end
                end
                ARB_IF: begin
                    if (mem_ready_i) begin
                        state       <= ARB_RESP;
                        mem_valid_o <= 1'b0;
                        if_rdata_o  <= word_sel(mem_rdata_i, wsel);
                        // A redirect in the completion cycle itself also kills the response.
                        if_ready_o  <= !(drop || flush_i);
                        drop        <= 1'b0;
                    end else if (flush_i) begin
                        drop <= 1'b1;
                    end
                end
                ARB_LSU: begin
                    if (mem_ready_i) begin
                        state       <= ARB_RESP;
                        mem_valid_o <= 1'b0;
                        lsu_rdata_o <= mem_rdata_i;
                        lsu_ready_o <= 1'b1;
                    end
                end
                ARB_RESP: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_mem_arbiter.sv
// tb_ysyx_22041412_mem_arbiter: transaction-level model plus directed and random traffic for the memory arbiter
module tb_ysyx_22041412_mem_arbiter;
    import ysyx_22041412_mem_arbiter_pkg::*;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_ready_o;
    logic [31:0] if_rdata_o;
    logic        flush_i = 1'b0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [31:0] lsu_addr_i = '0;
    logic [63:0] lsu_wdata_i = '0;
    logic [7:0]  lsu_wstrb_i = '0;
    logic        lsu_ready_o;
    logic [63:0] lsu_rdata_o;
    logic        mem_valid_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_ready_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    ysyx_22041412_mem_arbiter #(.IF_WAIT_MAX(MAX), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
        .flush_i(flush_i),
        .lsu_valid_i(lsu_valid_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_wstrb_i(lsu_wstrb_i), .lsu_ready_o(lsu_ready_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one outstanding transaction record, a pending-response flag, and IF's waiting time.
    typedef struct packed {
        logic        is_if;
        logic        hi;
        logic [31:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    req_t        m_cur = '0;
    logic        m_busy = 1'b0;
    logic        m_resp = 1'b0;
    logic        m_drop = 1'b0;
    int          m_wait = 0;
    logic        e_if_ready = 1'b0;
    logic        e_lsu_ready = 1'b0;
    logic [31:0] e_if_rdata = '0;
    logic [63:0] e_lsu_rdata = '0;

    task automatic model_step();
        logic gi, gl, own_if;
        if (rst) begin
            m_busy = 0; m_resp = 0; m_drop = 0; m_wait = 0; e_if_ready = 0; e_lsu_ready = 0;
            return;
        end
        gi = 0;
        gl = 0;
        if (!m_busy && !m_resp) begin
            if (lsu_valid_i && !(if_valid_i && m_wait == MAX)) gl = 1;
            else if (if_valid_i) gi = 1;
        end
        own_if = (m_busy || m_resp) && m_cur.is_if;
        if (!if_valid_i || gi) m_wait = 0;
        else if (!own_if && m_wait < MAX) m_wait++;
        e_if_ready = 0;
        e_lsu_ready = 0;
        if (m_resp) m_resp = 0;
        else if (m_busy) begin
            if (m_cur.is_if && flush_i) m_drop = 1;
            if (mem_ready_i) begin
                m_busy = 0;
                m_resp = 1;
                if (m_cur.is_if) begin
                    e_if_rdata = m_cur.hi ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
                    e_if_ready = !m_drop;
                    m_drop = 0;
                end else begin
                    e_lsu_rdata = mem_rdata_i;
                    e_lsu_ready = 1;
                end
            end
        end else if (gl) begin
            m_cur = '{1'b0, 1'b0, lsu_addr_i, lsu_we_i, lsu_wdata_i, lsu_wstrb_i};
            m_busy = 1;
        end else if (gi) begin
            m_cur = '{1'b1, if_addr_i[2], if_addr_i & ~32'h7, 1'b0, 64'h0, 8'h0};
            m_busy = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        chk("mem_valid", mem_valid_o, m_busy);
        if (m_busy) begin
            chk("mem_addr", mem_addr_o, m_cur.addr);
            chk("mem_we", mem_we_o, m_cur.we);
            chk("mem_wstrb", mem_wstrb_o, m_cur.wstrb);
            if (!m_cur.is_if) chk("mem_wdata", mem_wdata_o, m_cur.wdata);
        end
        chk("if_ready", if_ready_o, e_if_ready);
        chk("lsu_ready", lsu_ready_o, e_lsu_ready);
        if (e_if_ready) chk("if_rdata", if_rdata_o, e_if_rdata);
        if (e_lsu_ready) chk("lsu_rdata", lsu_rdata_o, e_lsu_rdata);
        chk("wait_cnt", dut.u_prio.wait_cnt, m_wait);
    end

    // Cache model: answers after mem_delay cycles; late_req asks for one stray ready pulse.
    int          mem_delay = 1;
    int          mem_cnt = 0;
    logic        mem_auto = 1'b1;
    logic        mem_rand = 1'b0;
    logic [63:0] mem_data = '0;
    int          late_req = 0;
    int          late_done = 0;

    initial forever begin
        @(negedge clk);
        if (late_req != late_done) begin
            late_done = late_req;
            mem_ready_i = 1;
            mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (mem_ready_i) mem_ready_i = 0;
        else if (mem_auto && mem_valid_o) begin
            if (mem_cnt >= mem_delay) begin
                mem_ready_i = 1;
                mem_rdata_i = mem_rand ? {$urandom, $urandom} : mem_data;
                mem_cnt = 0;
                if (mem_rand) mem_delay = $urandom_range(0, 3);
            end else mem_cnt++;
        end else mem_cnt = 0;
    end

    function automatic logic sig(input int w);
        return w == 0 ? if_ready_o : w == 1 ? lsu_ready_o : mem_valid_o;
    endfunction

    task automatic wait_for(input int w, input string name, output int n);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (sig(w)) return;
        end
        chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n, low, reqs;
        logic prev, bad;
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_if_ready", if_ready_o, 0);
        chk("rst_lsu_ready", lsu_ready_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_lsu_rdata", lsu_rdata_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        rst = 0;
        @(negedge clk);

        // IF only, upper word select
        mem_delay = 1;
        mem_data = 64'h1111_2222_3333_4444;
        if_addr_i = 32'h8000_0004;
        if_valid_i = 1;
        wait_for(2, "t1_req", n);
        chk("t1_grant_lat", n, 1);
        chk("t1_mem_addr", mem_addr_o, 32'h8000_0000);
        wait_for(0, "t1_ready", n);
        chk("t1_ready_lat", n, 2);
        chk("t1_rdata", if_rdata_o, 32'h1111_2222);
        chk("t1_lsu_ready", lsu_ready_o, 0);
        if_valid_i = 0;
        @(negedge clk);
        chk("t1_pulse", if_ready_o, 0);
        repeat (2) @(negedge clk);

        // simultaneous requests: LSU store first, then IF
        mem_data = 64'h5555_6666_7777_8888;
        if_addr_i = 32'h8000_0040;
        if_valid_i = 1;
        lsu_valid_i = 1;
        lsu_we_i = 1;
        lsu_addr_i = 32'h8000_1000;
        lsu_wdata_i = 64'hDEAD_BEEF_0000_0000;
        lsu_wstrb_i = 8'hF0;
        wait_for(2, "t2_req", n);
        chk("t2_we", mem_we_o, 1);
        chk("t2_addr", mem_addr_o, 32'h8000_1000);
        chk("t2_wdata", mem_wdata_o, 64'hDEAD_BEEF_0000_0000);
        chk("t2_wstrb", mem_wstrb_o, 8'hF0);
        wait_for(1, "t2_lsu_ready", n);
        lsu_valid_i = 0;
        lsu_we_i = 0;
        low = 0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (mem_valid_o) break;
            low++;
        end
        chk("t2_gap", low >= 1, 1);
        chk("t2_if_addr", mem_addr_o, 32'h8000_0040);
        chk("t2_if_we", mem_we_o, 0);
        wait_for(0, "t2_if_ready", n);
        chk("t2_if_rdata", if_rdata_o, 32'h7777_8888);
        if_valid_i = 0;
        repeat (2) @(negedge clk);

        // LSU streaming continuously; IF must still get in
        lsu_addr_i = 32'h8000_2000;
        lsu_valid_i = 1;
        if_addr_i = 32'h8000_0200;
        if_valid_i = 1;
        bad = 1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (lsu_ready_o) lsu_addr_i += 8;
            if (mem_valid_o && mem_addr_o == 32'h8000_0200) begin
                bad = 0;
                break;
            end
        end
        chk("t3_if_granted", bad, 0);
        chk("t3_if_wait", n <= 5, 1);
        chk("t3_wait_cleared", dut.u_prio.wait_cnt, 0);
        wait_for(0, "t3_if_ready", n);
        if_valid_i = 0;
        wait_for(1, "t3_lsu_ready", n);
        lsu_valid_i = 0;
        repeat (2) @(negedge clk);

        // flush during a slow fetch; the redirected fetch completes normally
        mem_delay = 3;
        mem_data = 64'hAAAA_BBBB_CCCC_DDDD;
        if_addr_i = 32'h8000_0020;
        if_valid_i = 1;
        wait_for(2, "t4_req", n);
        flush_i = 1;
        if_addr_i = 32'h8000_0100;
        @(negedge clk);
        flush_i = 0;
        reqs = 1;
        prev = 1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (mem_valid_o && !prev) reqs++;
            prev = mem_valid_o;
            if (if_ready_o) break;
        end
        chk("t4_ready_seen", if_ready_o, 1);
        chk("t4_reqs", reqs, 2);
        chk("t4_rdata", if_rdata_o, 32'hCCCC_DDDD);
        if_valid_i = 0;
        mem_delay = 1;
        repeat (2) @(negedge clk);

        // reset in the middle of an LSU access; a late cache ready is ignored
        mem_auto = 0;
        lsu_we_i = 0;
        lsu_addr_i = 32'h8000_0010;
        lsu_valid_i = 1;
        wait_for(2, "t5_req", n);
        @(negedge clk);
        rst = 1;
        lsu_valid_i = 0;
        @(negedge clk);
        chk("t5_mem_valid", mem_valid_o, 0);
        chk("t5_state", dut.state, ARB_IDLE);
        rst = 0;
        late_req++;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (lsu_ready_o || if_ready_o || mem_valid_o) bad = 1;
        end
        chk("t5_quiet", bad, 0);
        mem_auto = 1;

        // LSU load
        mem_data = 64'h0123_4567_89AB_CDEF;
        lsu_addr_i = 32'h8000_0008;
        lsu_valid_i = 1;
        wait_for(1, "t6_ready", n);
        chk("t6_rdata", lsu_rdata_o, 64'h0123_4567_89AB_CDEF);
        lsu_valid_i = 0;
        @(negedge clk);
        chk("t6_pulse", lsu_ready_o, 0);
        repeat (2) @(negedge clk);

        // random traffic against the model
        mem_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            flush_i = ($urandom_range(0, 11) == 0);
            if (rst) begin
                if_valid_i = 0;
                lsu_valid_i = 0;
                continue;
            end
            if (if_valid_i) begin
                if (if_ready_o) begin
                    if_valid_i = ($urandom_range(0, 2) == 0);
                    if_addr_i = $urandom & 32'hFFFF_FFFC;
                end else if (flush_i) if_addr_i = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 2) == 0) begin
                if_valid_i = 1;
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (lsu_valid_i ? lsu_ready_o : ($urandom_range(0, 2) == 0)) begin
                lsu_valid_i = lsu_valid_i ? ($urandom_range(0, 2) == 0) : 1'b1;
                lsu_we_i = $urandom_range(0, 1) == 1;
                lsu_addr_i = $urandom;
                lsu_wdata_i = {$urandom, $urandom};
                lsu_wstrb_i = 8'($urandom);
            end
        end
        rst = 0;
        flush_i = 0;
        if_valid_i = 0;
        lsu_valid_i = 0;
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22041412_mem_arbiter.md
Name: ysyx_22041412_mem_arbiter

Overview:
- Shares the single cache/memory port between instruction fetch (IF, read-only) and the load/store unit (LSU, read/write).
- Sits between the IF/LSU stages and the cache.
- Fixed LSU priority, plus an anti-starvation counter that eventually forces an IF grant.
- One transaction in flight at a time; no preemption once a grant is issued.

Parameters:
- IF_WAIT_MAX, 4, number of cycles IF may wait while LSU wins before IF gets forced priority (range 1..15).
- ADDR_W, 32, address width on all ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid_i  in  1  IF read request
- if_addr_i  in  32  IF fetch address; bits [1:0] are 0
- if_ready_o  out  1  one-cycle pulse: if_rdata_o valid
- if_rdata_o  out  32  instruction word
- flush_i  in  1  branch redirect; discards the in-flight IF response
- lsu_valid_i  in  1  LSU request
- lsu_we_i  in  1  1 = write
- lsu_addr_i  in  32  LSU address
- lsu_wdata_i  in  64  write data
- lsu_wstrb_i  in  8  byte strobes
- lsu_ready_o  out  1  one-cycle pulse: access complete, lsu_rdata_o valid
- lsu_rdata_o  out  64  load data
- mem_valid_o  out  1  request to cache
- mem_we_o  out  1  write enable
- mem_addr_o  out  32  address
- mem_wdata_o  out  64  write data
- mem_wstrb_o  out  8  strobes
- mem_ready_i  in  1  cache done; mem_rdata_i valid this cycle
- mem_rdata_i  in  64  read data

Behaviour:
- Reset values: all outputs 0; state IDLE; wait counter 0; drop flag 0.
- Reset is synchronous. Reset mid-transaction returns to IDLE and drops mem_valid_o at that edge; the response is abandoned.
- States: IDLE, IF_BUSY, LSU_BUSY, RESP.
- IDLE grant rule:
  - If lsu_valid_i and not (if_valid_i and wait counter == IF_WAIT_MAX), grant LSU.
  - Else if if_valid_i, grant IF.
  - On grant, latch the request fields into the mem_* registers, set mem_valid_o = 1 and enter the *_BUSY state at the next edge. Grant to mem_valid_o latency is 1 cycle.
- IF request on the memory side:
  - mem_addr_o = if_addr_i with [2:0] cleared; mem_we_o = 0; mem_wstrb_o = 0.
  - Latch if_addr_i[2] as the word select.
- LSU request on the memory side: address, we, wdata and wstrb are forwarded unmodified.
- *_BUSY: hold mem_* stable with mem_valid_o = 1 until mem_ready_i. On mem_ready_i:
  - Register the response data.
  - Clear mem_valid_o.
  - Enter RESP.
- RESP lasts one cycle:
  - Assert the granted requester's ready for exactly this cycle.
  - IF data = word-select ? mem_rdata_i[63:32] : mem_rdata_i[31:0].
  - Then go to IDLE.
  - Minimum request-to-ready time is 4 cycles when the cache answers in 1 cycle.
- Requester valid seen high in IDLE after its ready pulse is treated as a new request. Requesters must drop valid in the cycle after ready if they have no further request.
- Flush:
  - flush_i during IF_BUSY, or in the same cycle as IF mem_ready_i, sets the drop flag. RESP then suppresses if_ready_o (data may update) and the flag clears.
  - flush_i in IDLE has no effect on arbitration.
  - flush_i during LSU_BUSY is ignored.
- Wait counter:
  - Increments (saturating at IF_WAIT_MAX) each cycle if_valid_i = 1 and IF is not granted.
  - Cleared on IF grant or when if_valid_i = 0.
- Simultaneous IF and LSU valid with counter < max: LSU wins, and IF is granted at the next IDLE.
- Back-to-back traffic: at least one IDLE cycle exists between transactions, so the arbiter never issues two mem requests without a mem_valid_o low cycle.
- mem_ready_i while not BUSY is ignored.
- Request inputs are not sampled outside IDLE.

Decomposition:
- Shared package (ysyx_22041412 defines): state encodings ARB_IDLE/ARB_IF/ARB_LSU/ARB_RESP, IF_WAIT_MAX default.
- One natural sub-module: ysyx_22041412_arb_prio, a combinational grant decision plus the saturating wait counter.
- Request latching, the FSM and response muxing stay in the top module.

Test Plan:
- IF only, if_addr_i = 0x80000004, mem_rdata_i = 0x11112222_33334444, cache ready 1 cycle after mem_valid_o -> mem_addr_o = 0x80000000, if_rdata_o = 0x11112222, if_ready_o pulses 1 cycle, lsu_ready_o stays 0.
- IF and LSU valid in the same cycle, LSU store to 0x80001000, wdata 0xDEADBEEF_00000000, wstrb 0xF0 -> LSU served first with mem_we_o = 1 and exact fields; IF served next; mem_valid_o low for at least 1 cycle between the two.
- LSU held valid continuously plus IF valid, IF_WAIT_MAX = 4 -> IF granted no later than its 5th waiting cycle; counter back to 0 after the IF grant.
- flush_i pulsed while IF_BUSY with the cache delaying 3 cycles -> transaction completes on mem, if_ready_o never asserts; a following IF request to 0x80000100 completes normally.
- rst asserted while LSU_BUSY -> next edge: mem_valid_o = 0, state IDLE, no ready pulses; a late mem_ready_i is ignored.
- LSU load from 0x80000008, mem_rdata_i = 0x0123456789ABCDEF -> lsu_rdata_o = 0x0123456789ABCDEF with lsu_ready_o for exactly 1 cycle.
